frame_checker: RTL

FRAME_CHECKER -- requirements
Module: frame_checker

---
 rtl/mii_pkg.sv | 33 +++
 rtl/rx_word_classifier.sv | 41 ++++
 rtl/frame_checker.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mii_pkg.sv
// Shared definitions for the MII receive frame checker: control/payload byte codes,
// the receive word classes, the checker FSM states and the frame error codes.
// No ports; imported by rx_word_classifier and frame_checker.
package mii_pkg;

    localparam logic [7:0] C_IDLE_CODE    = 8'h07;
    localparam logic [7:0] C_START_CODE   = 8'hFB;
    localparam logic [7:0] C_EOF_CODE     = 8'hFD;
    localparam logic [7:0] C_DATA_PATTERN = 8'hAA;

    typedef enum logic [2:0] {
        W_DATA    = 3'd0,
        W_START   = 3'd1,
        W_EOF     = 3'd2,
        W_IDLE    = 3'd3,
        W_BADCTRL = 3'd4
    } word_class_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SHORT   = 3'd1,
        ERR_LONG    = 3'd2,
        ERR_PATTERN = 3'd3,
        ERR_RESTART = 3'd4,
        ERR_ABORT   = 3'd5
    } err_code_e;

endpackage

// File: rtl/rx_word_classifier.sv
// Classifies one receive word as DATA / START / EOF / IDLE / BADCTRL.
// Latency: purely combinational. Backpressure: none, evaluates every cycle.
// Ports: i_rx_data (8-bit lanes, lane 0 = [7:0]), i_rx_ctrl (nonzero = control word), o_cls.
module rx_word_classifier
    import mii_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = 8,
    parameter logic [7:0] IDLE_CODE  = C_IDLE_CODE,
    parameter logic [7:0] START_CODE = C_START_CODE,
    parameter logic [7:0] EOF_CODE   = C_EOF_CODE
) (
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output word_class_e           o_cls
);

    localparam int LANES = DATA_WIDTH / 8;

    logic w_any_eof;
    logic w_all_idle;

    always_comb begin
        w_any_eof  = 1'b0;
        w_all_idle = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (i_rx_data[8*i +: 8] == EOF_CODE)  w_any_eof  = 1'b1;
            if (i_rx_data[8*i +: 8] != IDLE_CODE) w_all_idle = 1'b0;
        end
    end

    // START wins over EOF, which wins over IDLE; any other control word is malformed.
    always_comb begin
        o_cls = W_BADCTRL;
        if (i_rx_ctrl == '0)                      o_cls = W_DATA;
        else if (i_rx_data[7:0] == START_CODE)    o_cls = W_START;
        else if (w_any_eof)                       o_cls = W_EOF;
        else if (w_all_idle)                      o_cls = W_IDLE;
    end

endmodule

// File: rtl/frame_checker.sv
// Checks received frames for length, payload pattern and framing; reports each close and keeps good/bad counts.
// Latency: close report and stray pulse one cycle after the word is sampled. Backpressure: none, one word per cycle.
// Ports: clk, i_rst (sync high), i_rx_data/i_rx_ctrl in; o_frame_done/ok/len/err_code, o_stray, o_good_cnt/o_bad_cnt out.
module frame_checker
    import mii_pkg::*;
#(
    parameter int         DATA_WIDTH   = 64,
    parameter int         CTRL_WIDTH   = 8,
    parameter logic [7:0] IDLE_CODE    = C_IDLE_CODE,
    parameter logic [7:0] START_CODE   = C_START_CODE,
    parameter logic [7:0] EOF_CODE     = C_EOF_CODE,
    parameter logic [7:0] DATA_PATTERN = C_DATA_PATTERN,
    parameter int         MIN_BYTES    = 40,
    parameter int         MAX_BYTES    = 136
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic                  o_frame_done,
    output logic                  o_frame_ok,
    output logic [15:0]           o_frame_len,
    output logic [2:0]            o_err_code,
    output logic                  o_stray,
    output logic [15:0]           o_good_cnt,
    output logic [15:0]           o_bad_cnt
);

    localparam int          LANES = DATA_WIDTH / 8;
    localparam logic [15:0] MIN_B = 16'(MIN_BYTES);
    localparam logic [15:0] MAX_B = 16'(MAX_BYTES);

    word_class_e w_cls;

    rx_word_classifier #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH),
        .IDLE_CODE  (IDLE_CODE),
        .START_CODE (START_CODE),
        .EOF_CODE   (EOF_CODE)
    ) u_cls (
        .i_rx_data (i_rx_data),
        .i_rx_ctrl (i_rx_ctrl),
        .o_cls     (w_cls)
    );

    state_e     r_state;
    logic [7:0] r_cyc;
    logic       r_perr;
    logic       r_done;
    logic       r_ok;
    logic [15:0] r_len;
    err_code_e  r_code;
    logic       r_stray;
    logic [15:0] r_good;
    logic [15:0] r_bad;

    state_e     w_state_nxt;
    logic [7:0] w_cyc_nxt;
    logic       w_perr_nxt;
    logic       w_close;
    err_code_e  w_code;
    err_code_e  w_len_code;
    logic       w_stray;
    logic       w_pat_err;
    logic [15:0] w_bytes;

    always_comb begin
        w_pat_err = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i_rx_data[8*i +: 8] != DATA_PATTERN) w_pat_err = 1'b1;
        end
    end

    // Payload bytes of the open frame; counter saturates at 255 so this tops out at 2040.
    assign w_bytes = {5'd0, r_cyc, 3'd0};

    // Outcome of a normal (EOF) close: pattern error outranks the length checks.
    always_comb begin
        w_len_code = ERR_NONE;
        if (r_perr)                w_len_code = ERR_PATTERN;
        else if (w_bytes < MIN_B)  w_len_code = ERR_SHORT;
        else if (w_bytes > MAX_B)  w_len_code = ERR_LONG;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_perr_nxt  = r_perr;
        w_close     = 1'b0;
        w_code      = ERR_NONE;
        w_stray     = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (w_cls)
                    W_START: begin
                        w_cyc_nxt   = 8'd0;
                        w_perr_nxt  = 1'b0;
                        w_state_nxt = S_FRAME;
                    end
                    W_DATA, W_EOF: w_stray = 1'b1;
                    default: ;
                endcase
            end
            S_FRAME: begin
                case (w_cls)
                    W_DATA: begin
                        if (r_cyc != 8'hFF) w_cyc_nxt = r_cyc + 8'd1;
                        if (w_pat_err)      w_perr_nxt = 1'b1;
                    end
                    W_EOF: begin
                        w_close     = 1'b1;
                        w_code      = w_len_code;
                        w_state_nxt = S_IDLE;
                    end
                    // Close the running frame and open a fresh one on the same word.
                    W_START: begin
                        w_close    = 1'b1;
                        w_code     = ERR_RESTART;
                        w_cyc_nxt  = 8'd0;
                        w_perr_nxt = 1'b0;
                    end
                    default: begin
                        w_close     = 1'b1;
                        w_code      = ERR_ABORT;
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cyc   <= 8'd0;
            r_perr  <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_len   <= 16'd0;
            r_code  <= ERR_NONE;
            r_stray <= 1'b0;
            r_good  <= 16'd0;
            r_bad   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_perr  <= w_perr_nxt;
            r_done  <= w_close;
            r_stray <= w_stray;
            if (w_close) begin
                r_ok   <= (w_code == ERR_NONE);
                r_len  <= w_bytes;
                r_code <= w_code;
                if (w_code == ERR_NONE) begin
                    if (r_good != 16'hFFFF) r_good <= r_good + 16'd1;
                end else begin
                    if (r_bad != 16'hFFFF)  r_bad  <= r_bad + 16'd1;
                end
            end
        end
    end

    assign o_frame_done = r_done;
    assign o_frame_ok   = r_ok;
    assign o_frame_len  = r_len;
    assign o_err_code   = r_code;
    assign o_stray      = r_stray;
    assign o_good_cnt   = r_good;
    assign o_bad_cnt    = r_bad;

endmodule
